// File: rtl/aim65_term_ctrl.sv
// Byte-stream terminal sequencer for the aim65_video char RAM: tracks a COLS x ROWS cursor and scroll base.
// Printable byte: accept at N, write strobe at N+1, ready again at N+2; scroll and clear hold off input while busy.
module aim65_term_ctrl #(
  parameter int COLS        = 40,
  parameter int ROWS        = 25,
  parameter int SCROLL_HOLD = 8,
  parameter int SCROLL_WAIT = 64,
  parameter int CLEAR_WAIT  = 1024
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       video_ce,
  output logic       video_we,
  output logic [9:0] video_addr,
  output logic [7:0] video_data,
  output logic       video_clear,
  output logic       video_vscroll,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_SCROLL = 3'd2;
  localparam logic [2:0] S_SWAIT  = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;
  localparam logic [2:0] S_CWAIT  = 3'd5;

  localparam logic [10:0] RING    = 11'(COLS * ROWS);
  localparam logic [10:0] COLS_W  = 11'(COLS);
  localparam logic [5:0]  COL_MAX = 6'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
  localparam logic [10:0] HOLD_M1 = 11'(SCROLL_HOLD - 1);
  localparam logic [10:0] SW_M1   = 11'(SCROLL_WAIT - 1);
  localparam logic [10:0] CW_M1   = 11'(CLEAR_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [9:0]  base_q, base_d;
  logic [7:0]  data_q, data_d;
  logic [10:0] cnt_q, cnt_d;

  logic [10:0] addr_sum, base_sum;
  logic [9:0]  addr_phys, base_next;
  logic        accept, do_nl;

  // Ring addressing: the sum never reaches 2*RING, so one conditional subtract suffices.
  assign addr_sum  = 11'(base_q) + 11'(row_q) * COLS_W + 11'(col_q);
  assign addr_phys = (addr_sum >= RING) ? 10'(addr_sum - RING) : addr_sum[9:0];
  assign base_sum  = 11'(base_q) + COLS_W;
  assign base_next = (base_sum >= RING) ? 10'(base_sum - RING) : base_sum[9:0];

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    do_nl   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = in_data;
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_d = S_WRITE;
          end else begin
            case (in_data)
              8'h0D: col_d = '0;
              8'h0A: do_nl = 1'b1;
              8'h08: if (col_q != '0) col_d = col_q - 6'd1;
              8'h0C: begin
                state_d = S_CLEAR;
                col_d   = '0;
                row_d   = '0;
                base_d  = '0;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (col_q < COL_MAX) begin
          col_d = col_q + 6'd1;
        end else begin
          col_d = '0;
          do_nl = 1'b1;
        end
      end
      S_SCROLL: begin
        if (cnt_q == '0) begin
          state_d = S_SWAIT;
          cnt_d   = SW_M1;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_SWAIT, S_CWAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 11'd1;
      end
      S_CLEAR: begin
        state_d = S_CWAIT;
        cnt_d   = CW_M1;
      end
      default: state_d = S_IDLE;
    endcase

    // Line feed on the last row leaves the cursor there and moves the ring base instead.
    if (do_nl) begin
      if (row_q < ROW_MAX) begin
        row_d = row_q + 5'd1;
      end else begin
        state_d = S_SCROLL;
        cnt_d   = HOLD_M1;
        base_d  = base_next;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign video_ce      = (state_q == S_WRITE);
  assign video_we      = video_ce;
  assign video_addr    = video_ce ? addr_phys : '0;
  assign video_data    = video_ce ? data_q : '0;
  assign video_clear   = (state_q == S_CLEAR);
  assign video_vscroll = (state_q == S_SCROLL);
  assign cursor_col    = col_q;
  assign cursor_row    = row_q;
  assign busy          = (state_q != S_IDLE);

endmodule
